nibble_serial_addsub: RTL and testbench

//  Multi-precision add/subtract sequencer around one shared 4-bit add-with-carry slice.

---
 rtl/nibble_serial_addsub_pkg.sv | 12 +
 rtl/nibble_serial_addsub_if.sv | 28 ++
 rtl/nibble_serial_addsub_add4_cout_cin.sv | 21 ++
 rtl/nibble_serial_addsub.sv | 103 ++++++++++
 tb/tb_nibble_serial_addsub.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/nibble_serial_addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package nibble_serial_addsub_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_addsub_if.sv
// Operand/result handshake bundle between producer/consumer and the sequencer.
interface nibble_serial_addsub_if #(
  parameter int unsigned WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] o;
  logic             cout;

  // Producer/consumer side.
  modport master (
    output in_valid, i0, i1, sub, out_ready,
    input  in_ready, out_valid, o, cout
  );

  // Sequencer side.
  modport slave (
    input  in_valid, i0, i1, sub, out_ready,
    output in_ready, out_valid, o, cout
  );

endinterface

// File: rtl/nibble_serial_addsub_add4_cout_cin.sv
// Combinational 4-bit add-with-carry slice; the only adder in the sequencer.
module add4_cout_cin
  import nibble_serial_addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_i0,
  input  logic [NIBBLE_W-1:0] i_i1,
  input  logic                i_cin,
  output logic [NIBBLE_W-1:0] o_o,
  output logic                o_cout
);

  logic [NIBBLE_W:0] w_sum;

  // Widen by one bit so the carry-out falls out of the top.
  always_comb begin
    w_sum  = {1'b0, i_i0} + {1'b0, i_i1} + {{NIBBLE_W{1'b0}}, i_cin};
    o_o    = w_sum[NIBBLE_W-1:0];
    o_cout = w_sum[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-precision add/subtract: one nibble per cycle, LSB first, through a shared 4-bit slice.
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic                   i_clk,
  input logic                   i_resetn,
  nibble_serial_addsub_if.slave bus
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e              r_state;
  state_e              w_state_next;
  logic [IDX_W-1:0]    r_idx;
  logic                r_carry;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_o;
  logic                r_cout;

  logic                w_accept;
  logic                w_last;
  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_sum_nib;
  logic                w_slice_cout;

  // Select the current nibble of each operand for the shared slice.
  always_comb begin
    w_a_nib = r_a[NIBBLE_W*r_idx +: NIBBLE_W];
    w_b_nib = r_b[NIBBLE_W*r_idx +: NIBBLE_W];
  end

  add4_cout_cin u_add4 (
    .i_i0   (w_a_nib),
    .i_i1   (w_b_nib),
    .i_cin  (r_carry),
    .o_o    (w_sum_nib),
    .o_cout (w_slice_cout)
  );

  // Next-state logic and handshake outputs.
  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    w_last        = (r_idx == LAST_IDX);
    bus.in_ready  = (r_state == StIdle);
    bus.out_valid = (r_state == StDone);
    unique case (r_state)
      StIdle: begin
        if (bus.in_valid) begin
          w_accept     = 1'b1;
          w_state_next = StRun;
        end
      end
      StRun: begin
        if (w_last) w_state_next = StDone;
      end
      StDone: begin
        if (bus.out_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) r_state <= StIdle;
    else           r_state <= w_state_next;
  end

  // Operand capture, nibble counter, carry chain and result assembly.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_o     <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      // Subtract as a + ~b + 1: invert b here and seed the carry with 1.
      r_a     <= bus.i0;
      r_b     <= bus.sub ? ~bus.i1 : bus.i1;
      r_carry <= bus.sub;
      r_idx   <= '0;
      r_o     <= '0;
    end else if (r_state == StRun) begin
      r_o[NIBBLE_W*r_idx +: NIBBLE_W] <= w_sum_nib;
      r_carry                          <= w_slice_cout;
      if (w_last) r_cout <= w_slice_cout;
      else        r_idx  <= r_idx + 1'b1;
    end
  end

  assign bus.o    = r_o;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed bench for the nibble-serial add/subtract sequencer (WIDTH=16).
module tb_nibble_serial_addsub;

  logic clk;
  logic resetn;
  int   n_vec;
  int   n_err;

  nibble_serial_addsub_if #(.WIDTH(16)) bus ();

  nibble_serial_addsub #(.WIDTH(16)) dut (
    .i_clk    (clk),
    .i_resetn (resetn),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, check latency and result, then complete the output handshake.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [15:0] exp_o, input logic exp_c);
    int cnt;
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.i0       = a;
    bus.i1       = b;
    bus.sub      = s;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.i0       = 16'hxxxx;
    bus.i1       = 16'hxxxx;
    bus.sub      = 1'bx;
    cnt = 0;
    while (!bus.out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    chk({tag, "_latency"}, cnt, 32'd4);
    chk({tag, "_o"}, {16'd0, bus.o}, {16'd0, exp_o});
    chk({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, exp_c});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_idle"}, {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    chk({tag, "_o_held"}, {16'd0, bus.o}, {16'd0, exp_o});
  endtask

  initial begin
    int cnt;
    logic seen;
    n_vec         = 0;
    n_err         = 0;
    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.i0        = '0;
    bus.i1        = '0;
    bus.sub       = 1'b0;

    // Reset held for two edges.
    tick();
    tick();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_o", {16'd0, bus.o}, 32'h0000);
    chk("rst_cout", {31'd0, bus.cout}, 32'd0);
    resetn = 1'b1;
    tick();

    do_op("add", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0);
    do_op("add_ovf", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    do_op("sub_nb", 16'h5000, 16'h0001, 1'b1, 16'h4FFF, 1'b1);
    do_op("sub_bor", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0);
    do_op("sub_eq", 16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1);

    // Backpressure: result held while a new request knocks.
    bus.i0 = 16'h1111; bus.i1 = 16'h2222; bus.sub = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.i0 = 16'h7777; bus.i1 = 16'h7777; bus.sub = 1'b1;
    cnt = 0;
    while (!bus.out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("bp_latency", cnt, 32'd4);
    for (int i = 0; i < 5; i++) begin
      chk("bp_o", {16'd0, bus.o}, 32'h3333);
      chk("bp_cout", {31'd0, bus.cout}, 32'd0);
      chk("bp_flags", {30'd0, bus.in_ready, bus.out_valid}, 32'b01);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_release", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    chk("bp_o_kept", {16'd0, bus.o}, 32'h3333);

    // Reset after two nibbles of an operation.
    bus.i0 = 16'hABCD; bus.i1 = 16'h1111; bus.sub = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("mid_busy", {31'd0, bus.in_ready}, 32'd0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_o", {16'd0, bus.o}, 32'h0000);
    chk("mid_cout", {31'd0, bus.cout}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    chk("mid_no_valid", {31'd0, seen}, 32'd0);
    do_op("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
